// File: rtl/aes_avalon_ctrl.sv
// aes_avalon_ctrl
// Avalon-MM slave that sequences one AES decryption at a time.
//   Register map (word addresses):
//     0-3   KEY     rw  word 0 = aes_key[127:96]
//     4-7   MSG_EN  rw  word 4 = aes_msg_en[127:96]
//     8-11  MSG_DE  ro  result captured from aes_msg_de
//     12    reserved, reads 0
//     13    STATUS  ro  {done_flag, timeout_flag, busy}
//     14    START   rw  bit0 only
//     15    DONE    ro  bit0 = done_flag
// Ports:
//   clk_clk, reset_reset_n  clock, asynchronous active-low reset
//   avs_*                   Avalon-MM slave (zero-wait-state combinational read)
//   export_data             {key[127:112], key[15:0]} for a hex display
//   aes_start/aes_key/aes_msg_en/aes_done/aes_msg_de  AES core handshake
//   irq                     level interrupt, done_flag | timeout_flag
module aes_avalon_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 4095
) (
   input  logic         clk_clk,
   input  logic         reset_reset_n,
   input  logic         avs_chipselect,
   input  logic         avs_read,
   input  logic         avs_write,
   input  logic [3:0]   avs_address,
   input  logic [3:0]   avs_byteenable,
   input  logic [31:0]  avs_writedata,
   output logic [31:0]  avs_readdata,
   output logic [31:0]  export_data,
   output logic         aes_start,
   output logic [127:0] aes_key,
   output logic [127:0] aes_msg_en,
   input  logic         aes_done,
   input  logic [127:0] aes_msg_de,
   output logic         irq
);

   typedef enum logic [1:0] {IDLE, RUN, CAPTURE, FIN} state_t;

   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state;
   logic [31:0] key_r [4];
   logic [31:0] men_r [4];
   logic [31:0] mde_r [4];
   logic        start_r;
   logic        done_flag;
   logic        timeout_flag;
   logic [15:0] cnt;

   logic        wr_en;
   logic        start_wr;
   logic        start_one;
   logic        start_zero;
   logic        busy;

   assign wr_en      = avs_chipselect & avs_write;
   assign start_wr   = wr_en && (avs_address == 4'd14) && avs_byteenable[0];
   assign start_one  = start_wr &  avs_writedata[0];
   assign start_zero = start_wr & ~avs_writedata[0];
   assign busy       = (state == RUN) || (state == CAPTURE);

   function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  be);
      logic [31:0] r;
      r = old_w;
      for (int unsigned b = 0; b < 4; b++)
         if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
      return r;
   endfunction

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state        <= IDLE;
         for (int unsigned i = 0; i < 4; i++) begin
            key_r[i] <= '0;
            men_r[i] <= '0;
            mde_r[i] <= '0;
         end
         start_r      <= 1'b0;
         done_flag    <= 1'b0;
         timeout_flag <= 1'b0;
         cnt          <= '0;
         aes_start    <= 1'b0;
      end else begin
         // KEY/MSG_EN are frozen while the core may be reading them
         if (wr_en && !busy && !avs_address[3]) begin
            if (!avs_address[2])
               key_r[avs_address[1:0]] <= merge_lanes(key_r[avs_address[1:0]], avs_writedata, avs_byteenable);
            else
               men_r[avs_address[1:0]] <= merge_lanes(men_r[avs_address[1:0]], avs_writedata, avs_byteenable);
         end
         if (start_wr)
            start_r <= avs_writedata[0];

         case (state)
            IDLE: begin
               if (start_one) begin
                  state        <= RUN;
                  aes_start    <= 1'b1;
                  cnt          <= '0;
                  done_flag    <= 1'b0;
                  timeout_flag <= 1'b0;
               end
            end
            RUN: begin
               // abort beats a coincident completion and the timeout
               if (start_zero) begin
                  state     <= IDLE;
                  aes_start <= 1'b0;
               end else if (aes_done) begin
                  state     <= CAPTURE;
                  aes_start <= 1'b0;
                  done_flag <= 1'b1;
                  mde_r[0]  <= aes_msg_de[127:96];
                  mde_r[1]  <= aes_msg_de[95:64];
                  mde_r[2]  <= aes_msg_de[63:32];
                  mde_r[3]  <= aes_msg_de[31:0];
               end else if (cnt == CNT_LAST) begin
                  state        <= FIN;
                  aes_start    <= 1'b0;
                  timeout_flag <= 1'b1;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            CAPTURE: state <= FIN;
            FIN: begin
               // only an explicit 0 write re-arms; a 1 write here is ignored
               if (start_zero) begin
                  state        <= IDLE;
                  done_flag    <= 1'b0;
                  timeout_flag <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      avs_readdata = '0;
      if (avs_chipselect && avs_read) begin
         case (avs_address)
            4'd0, 4'd1, 4'd2, 4'd3:   avs_readdata = key_r[avs_address[1:0]];
            4'd4, 4'd5, 4'd6, 4'd7:   avs_readdata = men_r[avs_address[1:0]];
            4'd8, 4'd9, 4'd10, 4'd11: avs_readdata = mde_r[avs_address[1:0]];
            4'd13: avs_readdata = {29'd0, done_flag, timeout_flag, busy};
            4'd14: avs_readdata = {31'd0, start_r};
            4'd15: avs_readdata = {31'd0, done_flag};
            default: avs_readdata = '0;
         endcase
      end
   end

   assign aes_key     = {key_r[0], key_r[1], key_r[2], key_r[3]};
   assign aes_msg_en  = {men_r[0], men_r[1], men_r[2], men_r[3]};
   assign export_data = {key_r[0][31:16], key_r[3][15:0]};
   assign irq         = done_flag | timeout_flag;

endmodule

// File: tb/tb_aes_avalon_ctrl.sv
// Self-checking bench for aes_avalon_ctrl with a transaction-level model.
module tb_aes_avalon_ctrl;

   localparam int unsigned T = 16;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         cs = 1'b0, rd = 1'b0, wr = 1'b0;
   logic [3:0]   addr = '0, be = '0;
   logic [31:0]  wdata = '0;
   logic [31:0]  rdata, export_data;
   logic         aes_start, aes_done = 1'b0, irq;
   logic [127:0] aes_key, aes_msg_en, aes_msg_de = '0;

   aes_avalon_ctrl #(.TIMEOUT_CYCLES(T)) dut (
      .clk_clk        (clk),
      .reset_reset_n  (rst_n),
      .avs_chipselect (cs),
      .avs_read       (rd),
      .avs_write      (wr),
      .avs_address    (addr),
      .avs_byteenable (be),
      .avs_writedata  (wdata),
      .avs_readdata   (rdata),
      .export_data    (export_data),
      .aes_start      (aes_start),
      .aes_key        (aes_key),
      .aes_msg_en     (aes_msg_en),
      .aes_done       (aes_done),
      .aes_msg_de     (aes_msg_de),
      .irq            (irq)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [31:0] m_key [4];
   logic [31:0] m_men [4];
   logic [31:0] m_mde [4];
   logic        m_start, m_done, m_tmo;

   typedef struct {
      logic [3:0]  a;
      logic [3:0]  b;
      logic [31:0] d;
      logic [31:0] exp;
   } vec_t;
   vec_t tbl [12];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] n, input logic [3:0] b);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = b[i/8] ? n[i] : o[i];
      return r;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 4; i++) begin
         m_key[i] = '0; m_men[i] = '0; m_mde[i] = '0;
      end
      m_start = 1'b0; m_done = 1'b0; m_tmo = 1'b0;
   endtask

   // write accepted while the controller is idle or finished
   task automatic model_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
      if (a < 4)       m_key[a]     = lanes(m_key[a], d, b);
      else if (a < 8)  m_men[a - 4] = lanes(m_men[a - 4], d, b);
      else if (a == 14 && b[0]) m_start = d[0];
   endtask

   function automatic logic [31:0] exp_read(input logic [3:0] a);
      if (a < 4)  return m_key[a];
      if (a < 8)  return m_men[a - 4];
      if (a < 12) return m_mde[a - 8];
      if (a == 13) return {29'd0, m_done, m_tmo, 1'b0};
      if (a == 14) return {31'd0, m_start};
      if (a == 15) return {31'd0, m_done};
      return 32'd0;
   endfunction

   task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
      @(negedge clk);
      cs = 1'b1; wr = 1'b1; addr = a; wdata = d; be = b;
      @(negedge clk);
      cs = 1'b0; wr = 1'b0; be = '0;
   endtask

   task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
      @(negedge clk);
      cs = 1'b1; rd = 1'b1; addr = a;
      #1 d = rdata;
      cs = 1'b0; rd = 1'b0;
   endtask

   task automatic read_check(input string name, input logic [3:0] a);
      logic [31:0] v;
      bus_read(a, v);
      check($sformatf("%s[%0d]", name, a), {96'd0, v}, {96'd0, exp_read(a)});
   endtask

   task automatic check_all_regs(input string name);
      for (int a = 0; a < 16; a++) read_check(name, 4'(a));
   endtask

   // One launch. Core raises aes_done in RUN cycle d (1-based); an abort
   // write lands in cycle abort_at (0 = none). Outcome follows from which
   // happens first relative to the T-cycle budget.
   task automatic run_case(input int d, input int abort_at, input bit prot,
                           input bit use_fixed, input logic [127:0] fixed);
      int outcome;   // 0 abort, 1 done, 2 timeout
      int last;
      bit prot_ok;
      logic [127:0] cap, men_before;
      logic [31:0] v;
      cap = '0;
      if (abort_at != 0) begin outcome = 0; last = abort_at; end
      else if (d <= int'(T)) begin outcome = 1; last = d; end
      else begin outcome = 2; last = int'(T); end
      prot_ok = prot && last >= 3;
      men_before = {m_men[0], m_men[1], m_men[2], m_men[3]};

      bus_write(4'd14, 32'd1, 4'h1);
      m_start = 1'b1;
      for (int c = 1; c <= int'(T) + 3; c++) begin
         check($sformatf("aes_start_c%0d", c), {127'd0, aes_start}, {127'd0, (c <= last)});
         aes_msg_de = {$urandom, $urandom, $urandom, $urandom};
         aes_done = (c == d);
         if (c == d) begin
            if (use_fixed) aes_msg_de = fixed;
            cap = aes_msg_de;
         end
         if (c == abort_at) begin
            cs = 1'b1; wr = 1'b1; addr = 4'd14; wdata = 32'd0; be = 4'h1;
         end else if (prot_ok && c == 2) begin
            cs = 1'b1; wr = 1'b1; addr = 4'd4; wdata = 32'hFFFF_FFFF; be = 4'hF;
         end else begin
            cs = 1'b0; wr = 1'b0; be = '0;
         end
         @(negedge clk);
      end
      cs = 1'b0; wr = 1'b0; be = '0; aes_done = 1'b0;

      if (outcome == 0) begin
         m_start = 1'b0; m_done = 1'b0; m_tmo = 1'b0;
      end else if (outcome == 1) begin
         m_done = 1'b1;
         m_mde[0] = cap[127:96]; m_mde[1] = cap[95:64];
         m_mde[2] = cap[63:32];  m_mde[3] = cap[31:0];
      end else begin
         m_tmo = 1'b1;
      end

      check("irq_after_run", {127'd0, irq}, {127'd0, m_done | m_tmo});
      check("msg_en_stable", aes_msg_en, men_before);
      read_check("status", 4'd13);
      read_check("done", 4'd15);
      for (int a = 8; a < 12; a++) read_check("msg_de", 4'(a));
      if (prot_ok) read_check("msg_en_prot", 4'd4);

      if (outcome != 0) begin
         // a 1 write in FIN must not relaunch
         bus_write(4'd14, 32'd1, 4'h1);
         m_start = 1'b1;
         @(negedge clk);
         check("no_relaunch", {127'd0, aes_start}, 128'd0);
         read_check("status_fin", 4'd13);
         bus_write(4'd14, 32'd0, 4'h1);
         m_start = 1'b0; m_done = 1'b0; m_tmo = 1'b0;
         check("irq_cleared", {127'd0, irq}, 128'd0);
         read_check("status_idle", 4'd13);
      end
      bus_read(4'd13, v);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] v;
      int d, ab;
      logic [3:0] ra, rb;
      logic [31:0] rd32;

      tbl[0]  = '{4'd0,  4'hF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
      tbl[1]  = '{4'd0,  4'h1, 32'h0000_0011, 32'hDEAD_BE11};
      tbl[2]  = '{4'd1,  4'h6, 32'hAABB_CCDD, 32'h00BB_CC00};
      tbl[3]  = '{4'd3,  4'h8, 32'h1234_5678, 32'h1200_0000};
      tbl[4]  = '{4'd4,  4'hF, 32'h0102_0304, 32'h0102_0304};
      tbl[5]  = '{4'd7,  4'h3, 32'hFFFF_FFFF, 32'h0000_FFFF};
      tbl[6]  = '{4'd8,  4'hF, 32'hFFFF_FFFF, 32'h0000_0000};
      tbl[7]  = '{4'd12, 4'hF, 32'hFFFF_FFFF, 32'h0000_0000};
      tbl[8]  = '{4'd13, 4'hF, 32'hFFFF_FFFF, 32'h0000_0000};
      tbl[9]  = '{4'd15, 4'hF, 32'hFFFF_FFFF, 32'h0000_0000};
      tbl[10] = '{4'd14, 4'hF, 32'hFFFF_FFFE, 32'h0000_0000};
      tbl[11] = '{4'd2,  4'h0, 32'hFFFF_FFFF, 32'h0000_0000};

      model_clear();
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("rst_aes_start", {127'd0, aes_start}, 128'd0);
      check("rst_irq", {127'd0, irq}, 128'd0);
      check("rst_export", {96'd0, export_data}, 128'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      check_all_regs("rst_reg");

      for (int i = 0; i < 12; i++) begin
         bus_write(tbl[i].a, tbl[i].d, tbl[i].b);
         model_write(tbl[i].a, tbl[i].d, tbl[i].b);
         bus_read(tbl[i].a, v);
         check($sformatf("vec%0d", i), {96'd0, v}, {96'd0, tbl[i].exp});
      end
      check("export_data", {96'd0, export_data}, {96'd0, 32'hDEAD_0000});
      check("aes_key", aes_key, 128'hDEADBE11_00BBCC00_00000000_12000000);
      check("aes_msg_en", aes_msg_en, 128'h01020304_00000000_00000000_0000FFFF);

      run_case(10, 0, 1, 1, 128'h0123456789ABCDEF_FEDCBA9876543210);
      run_case(int'(T) + 4, 0, 0, 0, '0);   // timeout
      run_case(int'(T), 0, 0, 0, '0);       // done on last allowed cycle
      run_case(int'(T) + 1, 0, 0, 0, '0);   // done one cycle late: timeout
      run_case(5, 5, 0, 0, '0);             // abort collides with done
      run_case(8, 3, 1, 0, '0);             // plain abort
      run_case(1, 0, 0, 0, '0);             // immediate done

      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 2) < 2) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rd32 = $urandom;
            if (ra == 4'd14) rd32[0] = 1'b0;
            bus_write(ra, rd32, rb);
            model_write(ra, rd32, rb);
            read_check("rnd_reg", ra);
         end else begin
            d = $urandom_range(1, int'(T) + 4);
            ab = 0;
            if ($urandom_range(0, 2) == 0)
               ab = $urandom_range(1, (d < int'(T)) ? d : int'(T));
            run_case(d, ab, 1, 0, '0);
         end
      end
      check("final_key", aes_key, {m_key[0], m_key[1], m_key[2], m_key[3]});

      // reset in the middle of a run
      bus_write(4'd14, 32'd1, 4'h1);
      @(negedge clk); @(negedge clk);
      check("pre_rst_start", {127'd0, aes_start}, 128'd1);
      #2 rst_n = 1'b0;
      #1;
      check("midrun_rst_start", {127'd0, aes_start}, 128'd0);
      check("midrun_rst_irq", {127'd0, irq}, 128'd0);
      check("midrun_rst_export", {96'd0, export_data}, 128'd0);
      @(negedge clk);
      rst_n = 1'b1;
      model_clear();
      check_all_regs("midrun_rst_reg");
      check("rst_key_out", aes_key, 128'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/aes_avalon_ctrl.md
AES_AVALON_CTRL -- requirements
Module: aes_avalon_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 4095, gives the maximum RUN cycles to wait for aes_done before flagging timeout; legal range 2..65535.
REQ-002 clk_clk  input  1  single system clock; all state on rising edge.
REQ-003 reset_reset_n  input  1  asynchronous, active-low reset.
REQ-004 avs_chipselect  input  1  Avalon-MM slave select.
REQ-005 avs_read  input  1  read strobe.
REQ-006 avs_write  input  1  write strobe.
REQ-007 avs_address  input  4  word address of register 0..15.
REQ-008 avs_byteenable  input  4  per-byte write enable, bit n = writedata[8n+7:8n].
REQ-009 avs_writedata  input  32  write data.
REQ-010 avs_readdata  output  32  read data.
REQ-011 export_data  output  32  {key[127:112], key[15:0]} for hex display.
REQ-012 aes_start  output  1  level request to AES core, high only in RUN.
REQ-013 aes_key  output  128  key, word 0 = bits [127:96].
REQ-014 aes_msg_en  output  128  encrypted message, word 4 = bits [127:96].
REQ-015 aes_done  input  1  core completion, sampled only in RUN.
REQ-016 aes_msg_de  input  128  decrypted result, valid when aes_done high.
REQ-017 irq  output  1  level interrupt = done_flag OR timeout_flag.

Function
REQ-018 Register map shall be: 0-3 KEY (rw), 4-7 MSG_EN (rw), 8-11 MSG_DE (ro), 12 reserved (reads 0), 13 STATUS (ro: bit0 busy, bit1 timeout_flag, bit2 done_flag, others 0), 14 START (rw, bit0 only, others read 0), 15 DONE (ro, bit0 = done_flag).
REQ-019 A write shall occur when chipselect AND write; only bytes with byteenable set shall update.
REQ-020 Writes to KEY/MSG_EN shall be ignored while in RUN or CAPTURE.
REQ-021 Writes to addresses 8-13 and 15 shall have no effect.
REQ-022 avs_readdata shall be combinational (zero wait states) when chipselect AND read; otherwise 0.
REQ-023 FSM states shall be IDLE, RUN, CAPTURE, FIN.
REQ-024 IDLE: START bit0 = 1 after a write -> RUN next cycle; timeout counter cleared, done_flag and timeout_flag cleared.
REQ-025 RUN: aes_start = 1; counter increments each cycle; aes_done = 1 -> CAPTURE; counter = TIMEOUT_CYCLES-1 with aes_done = 0 -> FIN with timeout_flag set.
REQ-026 CAPTURE: aes_msg_de latched into MSG_DE on entry edge (the RUN cycle aes_done was high); aes_start = 0; done_flag set; -> FIN after exactly one cycle.
REQ-027 FIN: hold until START bit0 written 0, then -> IDLE and clear done_flag and timeout_flag.
REQ-028 Write of START bit0 = 0 in RUN shall abort -> IDLE next cycle, MSG_DE unchanged, no flags set.
REQ-029 Simultaneous abort write and aes_done in RUN: abort shall win; MSG_DE not updated.
REQ-030 aes_done and aes_msg_de shall be ignored in IDLE, CAPTURE, FIN.
REQ-031 busy = 1 in RUN and CAPTURE, else 0.
REQ-032 START bit0 written 1 while FIN shall not relaunch; a 0 write must intervene.
REQ-033 Timeout counter shall be 16 bits, saturating never exceeded because RUN exits at TIMEOUT_CYCLES-1.

Reset
REQ-034 On reset_reset_n low, asynchronously: FSM = IDLE, all registers 0, flags 0, counter 0, aes_start 0, irq 0, export_data 0.
REQ-035 Reset asserted mid-RUN shall drop aes_start immediately, without waiting for a clock edge.
REQ-036 Release shall be synchronous to clk_clk; first usable access is the cycle after release.

Verification
REQ-037 Reset: pulse reset_reset_n low mid-RUN -> aes_start 0 immediately; all 16 registers read 0.
REQ-038 Byte-lane write: write 0xDEADBEEF to addr 0 byteenable 0xF, then 0x00000011 byteenable 0x1 -> readback 0xDEADBE11; export_data[31:16] = 0xDEAD.
REQ-039 Normal run: load KEY and MSG_EN, write START = 1, core raises aes_done 10 cycles later with msg_de = 0x0123..EF -> MSG_DE reads match, DONE = 1, irq = 1; write START = 0 -> IDLE, irq = 0.
REQ-040 Timeout: TIMEOUT_CYCLES = 16, aes_done held 0 -> FIN after 16 RUN cycles, STATUS = 0x2, irq = 1, MSG_DE unchanged.
REQ-041 Abort collision: in RUN write START = 0 in the same cycle aes_done = 1 -> IDLE, STATUS = 0, MSG_DE unchanged.
REQ-042 Busy protection: write 0xFFFFFFFF to addr 4 during RUN -> MSG_EN readback unchanged, aes_msg_en stable.
